// File: rtl/sram_dp.sv
// Dual-port word memory with power-on/clear fill engine (port A read/write, port B read-only).
// Optional macro SRAM_DP_BYPASS_EN: forward port A write data to a same-address port B read.
`timescale 1ns/1ps

module sram_dp #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 384,
  parameter int FILL_VALUE = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic                  i_a_write,
  input  logic [DATA_WIDTH-1:0] i_a_data,
  output logic [DATA_WIDTH-1:0] o_a_data,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  input  logic                  i_b_en,
  output logic [DATA_WIDTH-1:0] o_b_data,
  output logic                  o_b_valid,
  input  logic                  i_clear,
  output logic                  o_busy
);

  localparam logic [DATA_WIDTH-1:0] FILL_WORD = DATA_WIDTH'(FILL_VALUE);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    FILL = 1'b0,
    IDLE = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] fill_cnt_reg;
  logic                  busy_reg;
  logic [DATA_WIDTH-1:0] a_data_reg;
  logic [DATA_WIDTH-1:0] b_data_reg;
  logic                  b_valid_reg;

  logic                  a_in_range;
  logic                  b_in_range;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    a_in_range = ({1'b0, i_a_addr} < DEPTH_EXT);
    b_in_range = ({1'b0, i_b_addr} < DEPTH_EXT);
    mem_we     = 1'b0;
    mem_waddr  = fill_cnt_reg;
    mem_wdata  = FILL_WORD;
    // The fill engine owns the write port while busy; otherwise port A may write in range.
    if (i_rst_n) begin
      if (state_reg == FILL) begin
        mem_we = 1'b1;
      end else if (i_a_write && a_in_range) begin
        mem_we    = 1'b1;
        mem_waddr = i_a_addr;
        mem_wdata = i_a_data;
      end
    end
  end

`ifdef SRAM_DP_BYPASS_EN
  logic b_fwd;
  assign b_fwd = i_a_write && a_in_range && (i_a_addr == i_b_addr);
`endif

  // Storage is never reset; contents are established by the fill sequence.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= FILL;
      fill_cnt_reg <= '0;
      busy_reg     <= 1'b1;
      a_data_reg   <= '0;
      b_data_reg   <= '0;
      b_valid_reg  <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          b_valid_reg <= 1'b0;
          if (fill_cnt_reg == LAST_ADDR) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            fill_cnt_reg <= '0;
          end else begin
            fill_cnt_reg <= fill_cnt_reg + ADDR_WIDTH'(1);
          end
        end
        IDLE: begin
          if (!i_a_write) begin
            a_data_reg <= a_in_range ? mem[i_a_addr] : '0;
          end
          b_valid_reg <= i_b_en;
          if (i_b_en) begin
            if (!b_in_range) begin
              b_data_reg <= '0;
`ifdef SRAM_DP_BYPASS_EN
            end else if (b_fwd) begin
              b_data_reg <= i_a_data;
`endif
            end else begin
              b_data_reg <= mem[i_b_addr];
            end
          end
          if (i_clear) begin
            state_reg    <= FILL;
            busy_reg     <= 1'b1;
            fill_cnt_reg <= '0;
          end
        end
        default: begin
          state_reg    <= FILL;
          busy_reg     <= 1'b1;
          fill_cnt_reg <= '0;
        end
      endcase
    end
  end

  assign o_a_data  = a_data_reg;
  assign o_b_data  = b_data_reg;
  assign o_b_valid = b_valid_reg;
  assign o_busy    = busy_reg;

endmodule

// File: tb/tb_sram_dp.sv
// Randomized scoreboard bench for sram_dp: a cycle-level reference model pushes expected
// port A/B results into queues and a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_sram_dp;
  localparam int AW    = 9;
  localparam int DW    = 1;
  localparam int DEPTH = 384;
`ifdef SRAM_DP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] a_addr = '0;
  logic          a_write = 1'b0;
  logic [DW-1:0] a_data = '0;
  logic [AW-1:0] b_addr = '0;
  logic          b_en = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] o_a_data;
  logic [DW-1:0] o_b_data;
  logic          o_b_valid;
  logic          o_busy;

  always #5 clk = ~clk;

  sram_dp #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .FILL_VALUE(0)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_addr(a_addr), .i_a_write(a_write), .i_a_data(a_data), .o_a_data(o_a_data),
    .i_b_addr(b_addr), .i_b_en(b_en), .o_b_data(o_b_data), .o_b_valid(o_b_valid),
    .i_clear(clear), .o_busy(o_busy)
  );

  typedef struct {
    int            stamp;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          a_q[$];
  exp_t          b_q[$];
  exp_t          me, mon_a, mon_b;
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  logic [DW-1:0] last_a = '0;
  int            fill_left = DEPTH;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, exp);
  endtask

  // Reference: a fill blanks the whole memory and blocks the ports for DEPTH edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_left = DEPTH;
      last_a    = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else begin
      cyc++;
      if (fill_left > 0) begin
        fill_left--;
      end else begin
        if (b_en) begin
          me.stamp = cyc;
          if (int'(b_addr) >= DEPTH) me.data = '0;
          else if (BYPASS && a_write && a_addr == b_addr) me.data = a_data;
          else me.data = ref_mem[int'(b_addr)];
          b_q.push_back(me);
        end
        if (a_write) begin
          if (int'(a_addr) < DEPTH) ref_mem[int'(a_addr)] = a_data;
        end else begin
          last_a = (int'(a_addr) < DEPTH) ? ref_mem[int'(a_addr)] : '0;
        end
        if (clear) begin
          fill_left = DEPTH;
          for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end
      end
      me.stamp = cyc;
      me.data  = last_a;
      a_q.push_back(me);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", int'(o_busy), int'(fill_left > 0));
      if (a_q.size() > 0) begin
        mon_a = a_q.pop_front();
        check("a_data", int'(o_a_data), int'(mon_a.data));
      end
      check("b_valid", int'(o_b_valid), int'(b_q.size() > 0 && b_q[0].stamp == cyc));
      if (b_q.size() > 0 && b_q[0].stamp == cyc) begin
        mon_b = b_q.pop_front();
        check("b_data", int'(o_b_data), int'(mon_b.data));
      end
    end
  end

  task automatic step(input int aa, input logic aw, input logic ad,
                      input int ba, input logic be, input logic cl);
    a_addr  = AW'(aa);
    a_write = aw;
    a_data  = DW'(ad);
    b_addr  = AW'(ba);
    b_en    = be;
    clear   = cl;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic wait_fill();
    int k;
    k = 0;
    while (o_busy && k < 1000) begin
      idle(1);
      k++;
    end
    check("fill_finished", int'(o_busy), 0);
  endtask

  task automatic check_reset_outputs();
    #1;
    check("rst_a_data", int'(o_a_data), 0);
    check("rst_b_data", int'(o_b_data), 0);
    check("rst_b_valid", int'(o_b_valid), 0);
    check("rst_busy", int'(o_busy), 1);
  endtask

  initial begin
    int ra, rb;
    #3 rst_n = 1'b0;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_fill();

    for (int i = 0; i < DEPTH; i++) step(0, 1'b0, 1'b0, i, 1'b1, 1'b0);

    step(5, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0, 5, 1'b1, 1'b0);
    step(5, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    idle(1);

    step(10, 1'b1, 1'b1, 10, 1'b1, 1'b0);
    step(0, 1'b0, 1'b0, 10, 1'b1, 1'b0);
    idle(1);

    step(400, 1'b1, 1'b1, 400, 1'b1, 1'b0);
    step(400, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(i, 1'b0, 1'b0, i, 1'b1, 1'b0);

    for (int n = 0; n < 1500; n++) begin
      ra = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 511));
      rb = ($urandom_range(0, 2) == 0) ? ra : int'($urandom_range(0, 511));
      step(ra, 1'($urandom), 1'($urandom), rb, 1'($urandom), ($urandom_range(0, 399) == 0));
    end
    wait_fill();

    step(20, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    step(30, 1'b1, 1'b1, 30, 1'b1, 1'b0);
    idle(98);
    step(0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    wait_fill();
    step(20, 1'b0, 1'b0, 20, 1'b1, 1'b0);
    step(30, 1'b0, 1'b0, 30, 1'b1, 1'b0);
    idle(1);

    step(7, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    step(7, 1'b0, 1'b0, 7, 1'b1, 1'b0);
    step(0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    idle(199);
    #1 rst_n = 1'b0;
    check_reset_outputs();
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_fill();
    step(7, 1'b0, 1'b0, 7, 1'b1, 1'b0);
    idle(3);

    check("b_queue_drained", b_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
